// File: rtl/mem_bus_arbiter_pkg.sv
// Shared encodings for the two-requester memory port arbiter.
package mem_bus_arbiter_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE = 2'd0,
        ARB_BUSY = 2'd1,
        ARB_RESP = 2'd2
    } arb_state_t;

    localparam logic [31:0] ARB_ERROR_RDATA = 32'hDEAD_BEEF;

endpackage

// File: rtl/mem_bus_arbiter_rr_select2.sv
// Two-way round-robin pick: on contention the requester that did not win last goes next.
module rr_select2 (
    input  logic valid0,
    input  logic valid1,
    input  logic last_grant,
    output logic any,
    output logic winner
);

    assign any    = valid0 | valid1;
    assign winner = (valid0 & valid1) ? ~last_grant : valid1;

endmodule

// File: rtl/mem_bus_arbiter.sv
// Shares one valid/ready memory port between a CPU (m0) and a loader (m1); grant held per
// transaction, all outputs registered, watchdog aborts a stalled transaction with a sticky error.
module mem_bus_arbiter
    import mem_bus_arbiter_pkg::*;
#(
    parameter int unsigned          ADDR_BITS      = 32,
    parameter int unsigned          DATA_BITS      = 32,
    parameter int unsigned          TIMEOUT_CYCLES = 255,
    parameter logic [DATA_BITS-1:0] ERROR_RDATA    = DATA_BITS'(ARB_ERROR_RDATA)
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   m0_valid,
    input  logic [ADDR_BITS-1:0]   m0_addr,
    input  logic [DATA_BITS-1:0]   m0_wdata,
    input  logic [DATA_BITS/8-1:0] m0_wstrb,
    output logic                   m0_ready,
    output logic [DATA_BITS-1:0]   m0_rdata,
    input  logic                   m1_valid,
    input  logic [ADDR_BITS-1:0]   m1_addr,
    input  logic [DATA_BITS-1:0]   m1_wdata,
    input  logic [DATA_BITS/8-1:0] m1_wstrb,
    output logic                   m1_ready,
    output logic [DATA_BITS-1:0]   m1_rdata,
    output logic                   mem_valid,
    output logic [ADDR_BITS-1:0]   mem_addr,
    output logic [DATA_BITS-1:0]   mem_wdata,
    output logic [DATA_BITS/8-1:0] mem_wstrb,
    input  logic                   mem_ready,
    input  logic [DATA_BITS-1:0]   mem_rdata,
    output logic                   grant,
    output logic                   busy,
    input  logic                   clear_err,
    output logic                   timeout_err
);

    localparam logic [31:0] WD_LAST = (TIMEOUT_CYCLES == 0) ? 32'd0 : 32'(TIMEOUT_CYCLES - 1);

    arb_state_t             state_q, state_d;
    logic                   last_q, last_d;
    logic [31:0]            wd_q, wd_d;
    logic                   grant_d, busy_d, mem_valid_d, err_set, err_d;
    logic                   m0_ready_d, m1_ready_d;
    logic [DATA_BITS-1:0]   m0_rdata_d, m1_rdata_d, mem_wdata_d;
    logic [ADDR_BITS-1:0]   mem_addr_d;
    logic [DATA_BITS/8-1:0] mem_wstrb_d;
    logic                   any, winner;

    rr_select2 u_sel (
        .valid0     (m0_valid),
        .valid1     (m1_valid),
        .last_grant (last_q),
        .any        (any),
        .winner     (winner)
    );

    always_comb begin
        state_d     = state_q;
        last_d      = last_q;
        wd_d        = wd_q;
        grant_d     = grant;
        busy_d      = busy;
        mem_valid_d = mem_valid;
        mem_addr_d  = mem_addr;
        mem_wdata_d = mem_wdata;
        mem_wstrb_d = mem_wstrb;
        m0_ready_d  = 1'b0;
        m1_ready_d  = 1'b0;
        m0_rdata_d  = m0_rdata;
        m1_rdata_d  = m1_rdata;
        err_set     = 1'b0;
        case (state_q)
            ARB_IDLE: begin
                if (any) begin
                    state_d     = ARB_BUSY;
                    last_d      = winner;
                    grant_d     = winner;
                    busy_d      = 1'b1;
                    mem_valid_d = 1'b1;
                    wd_d        = '0;
                    mem_addr_d  = winner ? m1_addr  : m0_addr;
                    mem_wdata_d = winner ? m1_wdata : m0_wdata;
                    mem_wstrb_d = winner ? m1_wstrb : m0_wstrb;
                end
            end
            ARB_BUSY: begin
                wd_d = wd_q + 32'd1;
                // a real completion on the expiry cycle beats the abort
                if (mem_ready) begin
                    state_d     = ARB_RESP;
                    mem_valid_d = 1'b0;
                    m0_ready_d  = ~grant;
                    m1_ready_d  = grant;
                    if (grant) m1_rdata_d = mem_rdata;
                    else       m0_rdata_d = mem_rdata;
                end else if (TIMEOUT_CYCLES != 0 && wd_q == WD_LAST) begin
                    state_d     = ARB_RESP;
                    mem_valid_d = 1'b0;
                    m0_ready_d  = ~grant;
                    m1_ready_d  = grant;
                    err_set     = 1'b1;
                    if (grant) m1_rdata_d = ERROR_RDATA;
                    else       m0_rdata_d = ERROR_RDATA;
                end
            end
            ARB_RESP: begin
                state_d = ARB_IDLE;
                busy_d  = 1'b0;
                wd_d    = '0;
            end
            default: state_d = ARB_IDLE;
        endcase
        err_d = err_set | (timeout_err & ~clear_err);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ARB_IDLE;
            last_q      <= 1'b1;
            wd_q        <= '0;
            grant       <= 1'b0;
            busy        <= 1'b0;
            mem_valid   <= 1'b0;
            mem_addr    <= '0;
            mem_wdata   <= '0;
            mem_wstrb   <= '0;
            m0_ready    <= 1'b0;
            m1_ready    <= 1'b0;
            m0_rdata    <= '0;
            m1_rdata    <= '0;
            timeout_err <= 1'b0;
        end else begin
            state_q     <= state_d;
            last_q      <= last_d;
            wd_q        <= wd_d;
            grant       <= grant_d;
            busy        <= busy_d;
            mem_valid   <= mem_valid_d;
            mem_addr    <= mem_addr_d;
            mem_wdata   <= mem_wdata_d;
            mem_wstrb   <= mem_wstrb_d;
            m0_ready    <= m0_ready_d;
            m1_ready    <= m1_ready_d;
            m0_rdata    <= m0_rdata_d;
            m1_rdata    <= m1_rdata_d;
            timeout_err <= err_d;
        end
    end

endmodule
